// File: rtl/heichips25_template.sv
// Dual-channel complex correlator: averages X1*conj(X2) over 2^WINDOW_LOG2 samples.
// It drives the saturated mean real part on uo_out and the saturated mean imaginary part on uio_out.
module heichips25_template #(
    parameter int WINDOW_LOG2 = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int ACC_W = 9 + WINDOW_LOG2;
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(127);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -ACC_W'(128);

    logic signed [3:0]       i1_q, q1_q, i2_q, q2_q;
    logic signed [3:0]       i1_d, q1_d, i2_d, q2_d;
    logic                    s1_valid_q, s1_valid_d;
    logic signed [8:0]       re_q, im_q, re_d, im_d;
    logic                    s2_valid_q, s2_valid_d;
    logic signed [ACC_W-1:0] acc_re_q, acc_im_q, acc_re_d, acc_im_d;
    logic [WINDOW_LOG2-1:0]  cnt_q, cnt_d;
    logic [7:0]              uo_q, uio_q, uo_d, uio_d;

    logic signed [7:0]       p_ii, p_qq, p_qi, p_iq;
    logic signed [ACC_W-1:0] re_ext, im_ext, sum_re, sum_im;

    function automatic logic [7:0] sat8(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX)      return 8'h7F;
        else if (v < SAT_MIN) return 8'h80;
        else                  return v[7:0];
    endfunction

    always_comb begin
        // Each product of two 4-bit signed values fits in 8 bits; the extreme case is (-8)*(-8) = 64.
        p_ii = 8'(i1_q) * 8'(i2_q);
        p_qq = 8'(q1_q) * 8'(q2_q);
        p_qi = 8'(q1_q) * 8'(i2_q);
        p_iq = 8'(i1_q) * 8'(q2_q);

        re_ext = {{WINDOW_LOG2{re_q[8]}}, re_q};
        im_ext = {{WINDOW_LOG2{im_q[8]}}, im_q};
        sum_re = acc_re_q + re_ext;
        sum_im = acc_im_q + im_ext;

        // NOTE: default every _d to its _q first so no path through this block infers a latch.
        i1_d       = i1_q;
        q1_d       = q1_q;
        i2_d       = i2_q;
        q2_d       = q2_q;
        s1_valid_d = s1_valid_q;
        re_d       = re_q;
        im_d       = im_q;
        s2_valid_d = s2_valid_q;
        acc_re_d   = acc_re_q;
        acc_im_d   = acc_im_q;
        cnt_d      = cnt_q;
        uo_d       = uo_q;
        uio_d      = uio_q;

        if (ena) begin
            i1_d       = ui_in[3:0];
            q1_d       = ui_in[7:4];
            i2_d       = uio_in[7:4];
            q2_d       = uio_in[3:0];
            s1_valid_d = 1'b1;

            re_d       = 9'(p_ii) + 9'(p_qq);
            im_d       = 9'(p_qi) - 9'(p_iq);
            s2_valid_d = s1_valid_q;

            if (s2_valid_q) begin
                if (cnt_q == '1) begin
                    // The window-closing sample joins the sum on the same edge that publishes the mean.
                    uo_d     = sat8(sum_re >>> WINDOW_LOG2);
                    uio_d    = sat8(sum_im >>> WINDOW_LOG2);
                    acc_re_d = '0;
                    acc_im_d = '0;
                    cnt_d    = '0;
                end else begin
                    acc_re_d = sum_re;
                    acc_im_d = sum_im;
                    cnt_d    = cnt_q + WINDOW_LOG2'(1);
                end
            end
        end
    end

    // NOTE: rst_n is active-high here; a 1 asynchronously clears every register.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            i1_q       <= '0;
            q1_q       <= '0;
            i2_q       <= '0;
            q2_q       <= '0;
            s1_valid_q <= 1'b0;
            re_q       <= '0;
            im_q       <= '0;
            s2_valid_q <= 1'b0;
            acc_re_q   <= '0;
            acc_im_q   <= '0;
            cnt_q      <= '0;
            uo_q       <= 8'h00;
            uio_q      <= 8'h00;
        end else begin
            // NOTE: non-blocking assignments let every stage see the values from the previous edge.
            i1_q       <= i1_d;
            q1_q       <= q1_d;
            i2_q       <= i2_d;
            q2_q       <= q2_d;
            s1_valid_q <= s1_valid_d;
            re_q       <= re_d;
            im_q       <= im_d;
            s2_valid_q <= s2_valid_d;
            acc_re_q   <= acc_re_d;
            acc_im_q   <= acc_im_d;
            cnt_q      <= cnt_d;
            uo_q       <= uo_d;
            uio_q      <= uio_d;
        end
    end

    assign uo_out  = uo_q;
    assign uio_out = uio_q;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_heichips25_template.sv
// Directed bench for the complex correlator. The expected means are hand-computed from the sample values.
module tb_heichips25_template;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_checks = 0;
    int n_fail   = 0;

    heichips25_template dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample the outputs 1 time unit after the rising edge.
    task automatic cyc(input logic en, input logic [7:0] ui, input logic [7:0] uio);
        ena    = en;
        ui_in  = ui;
        uio_in = uio;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b1;
        #2;
        check({tag, "_rst_uo"},  uo_out,  8'h00);
        check({tag, "_rst_uio"}, uio_out, 8'h00);
        check({tag, "_rst_oe"},  uio_oe,  8'h00);
        rst_n = 1'b0;
        #1;
    endtask

    // Reset, then apply 8 identical samples and 2 zero samples.
    // The outputs must hold 0 after edge 9 and show the mean after edge 10.
    task automatic run_window(input string tag, input logic [7:0] ui, input logic [7:0] uio,
                              input logic [7:0] exp_uo, input logic [7:0] exp_uio);
        do_reset(tag);
        repeat (8) cyc(1'b1, ui, uio);
        cyc(1'b1, 8'h00, 8'h00);
        check({tag, "_e9_uo"},  uo_out,  8'h00);
        check({tag, "_e9_uio"}, uio_out, 8'h00);
        cyc(1'b1, 8'h00, 8'h00);
        check({tag, "_uo"},  uo_out,  exp_uo);
        check({tag, "_uio"}, uio_out, exp_uio);
    endtask

    initial begin
        rst_n  = 1'b1;
        ena    = 1'b0;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        @(posedge clk);
        #1;

        run_window("basic",  8'h20, 8'h02, 8'h04, 8'h00);
        run_window("mag",    8'h77, 8'h77, 8'h62, 8'h00);
        run_window("sat",    8'h88, 8'h88, 8'h7F, 8'h00);
        run_window("im_pos", 8'h70, 8'h70, 8'h00, 8'h31);
        run_window("im_neg", 8'h07, 8'h07, 8'h00, 8'hCF);

        // Seven samples with Re=1 give a sum of 7. Floor(7/8) = 0.
        do_reset("floor_pos");
        repeat (7) cyc(1'b1, 8'h01, 8'h10);
        repeat (3) cyc(1'b1, 8'h00, 8'h00);
        check("floor_pos_uo",  uo_out,  8'h00);
        check("floor_pos_uio", uio_out, 8'h00);

        // One sample with Re=-1 gives a sum of -1. Floor(-1/8) = -1.
        do_reset("floor_neg");
        cyc(1'b1, 8'h01, 8'hF0);
        repeat (9) cyc(1'b1, 8'h00, 8'h00);
        check("floor_neg_uo",  uo_out,  8'hFF);
        check("floor_neg_uio", uio_out, 8'h00);

        // Stall in the middle of a window. The inputs seen while ena=0 must be ignored.
        do_reset("stall");
        repeat (4) cyc(1'b1, 8'h77, 8'h77);
        repeat (5) begin
            cyc(1'b0, 8'h88, 8'h88);
            check("stall_oe", uio_oe, 8'h00);
            check("stall_uo", uo_out, 8'h00);
        end
        repeat (4) cyc(1'b1, 8'h77, 8'h77);
        cyc(1'b1, 8'h00, 8'h00);
        check("stall_e9_uo", uo_out, 8'h00);
        cyc(1'b1, 8'h00, 8'h00);
        check("stall_uo_final",  uo_out,  8'h62);
        check("stall_uio_final", uio_out, 8'h00);

        // Reset in the middle of a window. The outputs were 0x62 and must clear at once.
        repeat (4) cyc(1'b1, 8'h77, 8'h77);
        rst_n = 1'b1;
        #1;
        check("midrst_uo",  uo_out,  8'h00);
        check("midrst_uio", uio_out, 8'h00);
        check("midrst_oe",  uio_oe,  8'h00);
        rst_n = 1'b0;
        #1;
        repeat (8) cyc(1'b1, 8'h20, 8'h02);
        cyc(1'b1, 8'h00, 8'h00);
        check("midrst_e9_uo", uo_out, 8'h00);
        cyc(1'b1, 8'h00, 8'h00);
        check("midrst_next_uo",  uo_out,  8'h04);
        check("midrst_next_uio", uio_out, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
